// File: rtl/br_local_sink_pkg.sv
// Shared types and helpers for the BrLite local receive endpoint.
package br_local_sink_pkg;

  localparam int BR_ADDR_W = 16;

  typedef enum logic [1:0] {
    BR_SVC_NONE = 2'b00,
    BR_SVC_ALL  = 2'b01,
    BR_SVC_TGT  = 2'b10,
    BR_SVC_RSVD = 2'b11
  } br_svc_t;

  typedef struct packed {
    logic [BR_ADDR_W-1:0] src;
    logic [BR_ADDR_W-1:0] target;
    logic [31:0]          payload;
    br_svc_t              service;
  } br_rx_flit_t;

  // Address layout: x in the upper half, y in the lower half.
  function automatic logic [BR_ADDR_W-1:0] br_addr(input logic [BR_ADDR_W/2-1:0] x,
                                                    input logic [BR_ADDR_W/2-1:0] y);
    return {x, y};
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/br_local_sink_if.sv
// Router-side req/ack delivery plus PE-side valid/ready pop, bundled for one local port.
interface br_local_sink_if;
  import br_local_sink_pkg::*;

  logic        req_i;
  br_rx_flit_t flit_i;
  logic        ack_o;
  logic        valid_o;
  logic        ready_i;
  br_rx_flit_t data_o;

  modport slave  (input  req_i, flit_i, ready_i, output ack_o, valid_o, data_o);
  modport master (output req_i, flit_i, ready_i, input  ack_o, valid_o, data_o);
endinterface

// File: rtl/br_local_sink_fifo.sv
// br_sink_fifo: small synchronous FIFO, no bypass; head reads '0 while empty.
module br_sink_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push,
  input  logic                   pop,
  input  T                       wdata,
  output T                       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count/empty gate every read, so stale entries are never visible.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/br_local_sink.sv
// br_local_sink: req/ack receive FSM, service/address filter and saturating delivery counters.
module br_local_sink
  import br_local_sink_pkg::*;
#(
  parameter int          ADDR_W    = BR_ADDR_W,
  parameter int          DEPTH     = 4,
  parameter bit          DROP_SELF = 1'b1,
  parameter logic [15:0] CNT_INIT  = 16'h0000  // reset value of the delivery counters
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] local_addr_i,
  br_local_sink_if.slave    link,
  output logic [15:0]       rx_all_cnt_o,
  output logic [15:0]       rx_tgt_cnt_o,
  output logic [15:0]       filt_cnt_o
);
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ACK      = 2'd1;
  localparam logic [1:0] ST_WAIT_LOW = 2'd2;

  logic [1:0]              state;
  logic                    keep;
  logic                    accept;
  logic                    store;
  logic                    filt;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(DEPTH):0]  unused_fifo_count;

  // NOTE: combinational outputs get a default before the case so no path infers a latch.
  always_comb begin
    keep = 1'b0;
    case (link.flit_i.service)
      BR_SVC_TGT: keep = (link.flit_i.target == local_addr_i);
      BR_SVC_ALL: keep = !(DROP_SELF && (link.flit_i.src == local_addr_i));
      default:    keep = 1'b0;
    endcase
  end

  // Filtered flits never need FIFO space; stored ones wait while the FIFO is full.
  assign accept = (state == ST_IDLE) && link.req_i && (!keep || !fifo_full);
  assign store  = accept && keep;
  assign filt   = accept && !keep;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:     if (accept) state <= ST_ACK;
        ST_ACK:      state <= ST_WAIT_LOW;
        ST_WAIT_LOW: if (!link.req_i) state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

  assign link.ack_o   = (state == ST_ACK);
  assign link.valid_o = !fifo_empty;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_all_cnt_o <= CNT_INIT;
      rx_tgt_cnt_o <= CNT_INIT;
      filt_cnt_o   <= CNT_INIT;
    end else begin
      if (store && (link.flit_i.service == BR_SVC_ALL)) rx_all_cnt_o <= sat_inc16(rx_all_cnt_o);
      if (store && (link.flit_i.service == BR_SVC_TGT)) rx_tgt_cnt_o <= sat_inc16(rx_tgt_cnt_o);
      if (filt) filt_cnt_o <= sat_inc16(filt_cnt_o);
    end
  end

  br_sink_fifo #(
    .DEPTH (DEPTH),
    .T     (br_rx_flit_t)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (store),
    .pop   (link.valid_o && link.ready_i),
    .wdata (link.flit_i),
    .rdata (link.data_o),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (unused_fifo_count)
  );

endmodule

// File: doc/br_local_sink.md
# br_local_sink

Receive-side endpoint for the BrLite local port of one PE. Accepts broadcast flits delivered by the router over the req/ack handshake and filters them by service and target address. Buffers accepted flits in a small FIFO and presents them to the PE over a valid/ready interface. Keeps per-service delivery counters that testbenches compare against the injection scenario.

## Interface

Parameters:
- ADDR_W, 16, PE address width; x in [ADDR_W-1:ADDR_W/2], y in [ADDR_W/2-1:0]
- DEPTH, 4, FIFO entries; power of two, ≥2
- DROP_SELF, 1, when 1 discard BR_SVC_ALL flits whose src equals LOCAL address

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- local_addr_i  in  ADDR_W  this PE's address; static after reset
- req_i  in  1  router has a flit on flit_i
- flit_i  in  br_rx_flit_t  {src, target, payload[31:0], service}
- ack_o  out  1  flit consumed (stored or filtered)
- valid_o  out  1  FIFO head valid
- ready_i  in  1  PE pops head when valid_o && ready_i
- data_o  out  br_rx_flit_t  FIFO head
- rx_all_cnt_o  out  16  stored BR_SVC_ALL flits, saturating
- rx_tgt_cnt_o  out  16  stored BR_SVC_TGT flits, saturating
- filt_cnt_o  out  16  consumed-but-discarded flits, saturating

## Operation

- Handshake FSM states:
  - IDLE
  - ACK: ack_o=1 for exactly one cycle
  - WAIT_LOW: wait for req_i=0
- IDLE → ACK when req_i=1 and (flit is filtered or FIFO not full). Otherwise stay in IDLE with ack withheld (backpressure).
- ACK → WAIT_LOW unconditionally. WAIT_LOW → IDLE when req_i=0. A flit is never accepted twice per req pulse.
- Filter, evaluated in IDLE on flit_i:
  - BR_SVC_TGT: store iff target == local_addr_i; otherwise filter.
  - BR_SVC_ALL: store, except filter when DROP_SELF=1 and src == local_addr_i.
  - Any other service encoding: filter.
- Store: push flit into FIFO and increment the matching rx counter. Filter: increment filt_cnt_o. Both paths ack.
- All counters saturate at 16'hFFFF.
- FIFO: first-in first-out, no bypass. Pop only when valid_o && ready_i. Push and pop may occur in the same cycle.
- Full decision uses the current-cycle count, so a same-cycle pop does not allow a push when full.

## Timing

- Reset values:
  - state=IDLE, ack_o=0, valid_o=0, data_o='0
  - all counters 0, FIFO empty
- Reset mid-handshake returns to IDLE. Any in-flight ack is dropped, and a flit still held on req_i is re-evaluated as new after reset.
- Accept decision at cycle t (IDLE, req_i=1):
  - FIFO write and counter update at the t edge
  - ack_o=1 in cycle t+1
  - valid_o=1 in cycle t+1 if the FIFO was empty
- Minimum spacing between accepted flits: 3 cycles (IDLE, ACK, WAIT_LOW with req_i already low).
- Pop latency: head advances on the edge where valid_o && ready_i. The next entry appears on data_o the following cycle.
- Count width is $clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- full = (count == DEPTH). empty = (count == 0).

## Structure

- BrLitePkg gains:
  - br_rx_flit_t (packed: src, target, payload, service)
  - function br_addr(x, y)
  - reuse of the existing br_svc_t
- Sub-module br_sink_fifo: parameterised DEPTH/type synchronous FIFO with push, pop, full, empty, count. Instantiated once.
- The FSM, filter and counters stay in br_local_sink.

## Test plan

- Reset with req_i=1 held → ack_o=0 throughout reset; after release, ack_o=1 two cycles later; counters read 0 until the accept edge.
- local_addr=5; TGT flits with payloads 0xA8, 0xA0, 0xA6, 0xA1, target 5 → four acks; data_o pops 0xA8, 0xA0, 0xA6, 0xA1 in order; rx_tgt_cnt=4.
- local_addr=4; TGT flit target 6, payload 0xBA → acked, not stored, valid_o stays 0, filt_cnt=1.
- local_addr=0, DROP_SELF=1; ALL flits from src 0 (0x02), 4 (0x01), 3 (0x03) → 0x02 filtered; 0x01 then 0x03 stored; rx_all_cnt=2, filt_cnt=1.
- DEPTH=4, ready_i=0, five targeted flits → four acks, fifth req held without ack. One pop → fifth acked 2 cycles later. Pop with full and req present in the same cycle → no ack that cycle.
- Preload rx_tgt_cnt to 0xFFFE via 3 more stores → counter saturates and stays at 0xFFFF.
